skeeball_game_ctrl: RTL and testbench
=====================================

# skeeball_game_ctrl

Parametrised skee-ball game controller: the next generation of the four-state game sequencer. It adds internal trigger edge detection, an asynchronous reset, a per-game ball counter, a saturating score accumulator, a high-score register and an auto-timeout out of the finish screen. It sits between the debounced start/advance button and ball sensors on one side, and the display/score-formatting logic on the other, and drives both the encoded state and one-hot state flags.

## Interface
- NUM_BALLS, 9: balls per game. Must be ≥ 1.
- PTS_W, 7: width of per-ball point value.
- SCORE_W, 10: width of score and high score. Must be ≥ PTS_W.
- FINISH_CYCLES, 50000000: maximum cycles spent in FINISH before auto-advance. Must be ≥ 2.
- BALL_W (derived), $clog2(NUM_BALLS+1): width of balls_left.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- trigger  in  1  debounced, synchronous button level; acts on its rising edge only.
- ball_valid  in  1  one-cycle strobe: a ball scored.
- ball_points  in  PTS_W  points for the ball; valid with ball_valid.
- state  out  2  00 MENU, 01 PLAYING, 10 FINISH, 11 LAST_SCORE.
- menu_state, playing_state, finish_state, score_state  out  1 each  one-hot decode of state (combinational from state).
- balls_left  out  BALL_W  balls remaining in the current game.
- score  out  SCORE_W  current/last game score.
- high_score  out  SCORE_W  best score since reset.
- new_high  out  1  last finished game set a new high score.

## Operation
- Edge detect:
  - trig_q <= trigger every cycle.
  - trig_pulse = trigger & ~trig_q.
  - trig_q resets to 1, so a button held through reset does not advance.
- MENU:
  - On trig_pulse: go to PLAYING; score <= 0; balls_left <= NUM_BALLS; new_high <= 0.
  - score otherwise holds the previous game value.
- PLAYING:
  - On ball_valid: score <= min(score + ball_points, 2^SCORE_W − 1), computed at SCORE_W+1 bits; balls_left <= balls_left − 1.
  - If ball_valid and balls_left == 1: go to FINISH.
  - On trig_pulse (forfeit): go to FINISH; balls_left holds.
  - ball_valid and trig_pulse in the same cycle: the ball is counted, then FINISH.
- FINISH:
  - Timer resets to 0 on entry.
  - First FINISH cycle (timer == 0): if score > high_score, high_score <= score and new_high <= 1. An equal score does not update.
  - Go to LAST_SCORE on trig_pulse, or when timer == FINISH_CYCLES − 1.
  - A trig_pulse in the first FINISH cycle still performs the high-score compare in that cycle.
- LAST_SCORE: on trig_pulse, go to MENU. new_high holds until the next game start.
- ball_valid outside PLAYING is ignored: no score or count change.
- Reset (asynchronous, any time, including mid-game):
  - state = MENU, score = 0, high_score = 0, balls_left = 0, new_high = 0, timer = 0, trig_q = 1.
  - The one-hot outputs then read menu_state = 1, all others 0.

## Timing
- All outputs except the one-hot decode are registered.
- The one-hot decode is combinational from state and changes in the same cycle as state.
- Trigger latency:
  - trigger rises before edge k with trig_q = 0 → state changes at edge k.
  - A held trigger advances exactly once. It must go low for ≥ 1 sampled cycle to re-arm.
- Ball latency: ball_valid at edge k → score and balls_left updated at edge k. The final ball's state change to FINISH also occurs at edge k.
- high_score and new_high update at the edge ending the first FINISH cycle, i.e. one cycle after entering FINISH.
- Timeout: LAST_SCORE is entered exactly FINISH_CYCLES edges after FINISH entry.
- Timer width is $clog2(FINISH_CYCLES). The timer never wraps: it is cleared on leaving FINISH.

## Test plan
- Reset/trigger held: assert reset with trigger = 1, release → state stays 00 until trigger low for 1 cycle then high; menu_state = 1 throughout, all counters 0.
- Full game (NUM_BALLS = 3, FINISH_CYCLES = 4): trigger; balls 10, 20, 30 → score 60, balls_left 0, state 10 on third ball edge; high_score = 60 and new_high = 1 one cycle later; state 11 exactly 4 cycles after FINISH entry.
- Saturation (SCORE_W = 7, PTS_W = 7): three balls of 100 → score 127, never wraps.
- Forfeit with simultaneous ball: in PLAYING with balls_left 3, ball_valid (points 5) and trigger rising in the same cycle → score +5, balls_left 2, state 10.
- High-score compare: game 1 scores 50, game 2 scores 50 → high_score 50, new_high 0 after game 2; game 3 scores 51 → high_score 51, new_high 1; ball_valid in MENU/LAST_SCORE leaves score unchanged.
- Mid-game async reset: assert reset between clock edges while in PLAYING with score 40 → all outputs take their reset values immediately, before the next clk edge.

Source files
------------

// File: rtl/skeeball_game_ctrl.sv
// skeeball_game_ctrl: skee-ball game sequencer with trigger edge detect, ball
// counting, saturating score, high-score tracking and FINISH auto-timeout.
module skeeball_game_ctrl #(
    parameter int NUM_BALLS = 9,
    parameter int PTS_W = 7,
    parameter int SCORE_W = 10,
    parameter int FINISH_CYCLES = 50000000,
    localparam int BALL_W = $clog2(NUM_BALLS + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               trigger,
    input  logic               ball_valid,
    input  logic [PTS_W-1:0]   ball_points,
    output logic [1:0]         state,
    output logic               menu_state,
    output logic               playing_state,
    output logic               finish_state,
    output logic               score_state,
    output logic [BALL_W-1:0]  balls_left,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic               new_high
);
    localparam int TW = $clog2(FINISH_CYCLES);
    typedef enum logic [1:0] {MENU, PLAYING, FINISH, LAST_SCORE} state_t;
    state_t st, st_d;
    logic trig_q, trig_pulse, last_ball, timeout;
    logic [TW-1:0] timer;
    logic [SCORE_W:0] sum;
    logic [SCORE_W-1:0] score_sat;

    assign trig_pulse = trigger & ~trig_q;
    assign sum = {1'b0, score} + (SCORE_W+1)'(ball_points);
    assign score_sat = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    assign last_ball = ball_valid && balls_left == BALL_W'(1);
    assign timeout = timer == TW'(FINISH_CYCLES - 1);

    assign state = st;
    assign menu_state = st == MENU;
    assign playing_state = st == PLAYING;
    assign finish_state = st == FINISH;
    assign score_state = st == LAST_SCORE;

    always_comb begin
        st_d = st;
        case (st)
            MENU:    st_d = trig_pulse ? PLAYING : MENU;
            PLAYING: st_d = (trig_pulse || last_ball) ? FINISH : PLAYING;
            FINISH:  st_d = (trig_pulse || timeout) ? LAST_SCORE : FINISH;
            default: st_d = trig_pulse ? MENU : LAST_SCORE;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) st <= MENU;
        else st <= st_d;

    // trig_q resets high so a button held through reset cannot start a game
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trig_q <= 1'b1;
            score <= '0;
            high_score <= '0;
            balls_left <= '0;
            new_high <= 1'b0;
            timer <= '0;
        end else begin
            trig_q <= trigger;
            timer <= (st == FINISH && st_d == FINISH) ? timer + TW'(1) : '0;
            case (st)
                MENU: if (trig_pulse) begin
                    score <= '0;
                    balls_left <= BALL_W'(NUM_BALLS);
                    new_high <= 1'b0;
                end
                PLAYING: if (ball_valid) begin
                    score <= score_sat;
                    balls_left <= balls_left - BALL_W'(1);
                end
                FINISH: if (timer == '0 && score > high_score) begin
                    high_score <= score;
                    new_high <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_skeeball_game_ctrl.sv
// tb_skeeball_game_ctrl: directed and randomized checks of the skee-ball
// controller against a game-level reference model.
module tb_skeeball_game_ctrl;
    localparam int NB = 3, PW = 7, SW = 7, FC = 4, BW = 2;
    localparam int SMAX = (1 << SW) - 1;

    logic clk = 0, reset = 0, trigger = 0, ball_valid = 0;
    logic [PW-1:0] ball_points = '0;
    logic [1:0] state;
    logic menu_state, playing_state, finish_state, score_state, new_high;
    logic [BW-1:0] balls_left;
    logic [SW-1:0] score, high_score;

    int checks = 0, fails = 0;
    int m_st, m_score, m_balls, m_high, m_age;
    bit m_new, m_tq;

    skeeball_game_ctrl #(.NUM_BALLS(NB), .PTS_W(PW), .SCORE_W(SW), .FINISH_CYCLES(FC)) dut (
        .clk(clk), .reset(reset), .trigger(trigger), .ball_valid(ball_valid),
        .ball_points(ball_points), .state(state), .menu_state(menu_state),
        .playing_state(playing_state), .finish_state(finish_state),
        .score_state(score_state), .balls_left(balls_left), .score(score),
        .high_score(high_score), .new_high(new_high)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_st = 0; m_score = 0; m_balls = 0; m_high = 0; m_age = 0; m_new = 0; m_tq = 1;
    endtask

    function automatic logic [18:0] exp_vec();
        return {2'(m_st), BW'(m_balls), SW'(m_score), SW'(m_high), m_new};
    endfunction

    // Apply one cycle of inputs and advance the game model by the rules of play
    task automatic drive(input bit t, input bit bv, input int pts);
        bit p;
        @(negedge clk);
        trigger = t; ball_valid = bv; ball_points = PW'(pts);
        @(posedge clk);
        p = t && !m_tq;
        m_tq = t;
        case (m_st)
            0: if (p) begin m_st = 1; m_score = 0; m_balls = NB; m_new = 0; end
            1: begin
                if (bv) begin
                    m_score = (m_score + pts > SMAX) ? SMAX : m_score + pts;
                    m_balls = m_balls - 1;
                end
                if (p || (bv && m_balls == 0)) begin m_st = 2; m_age = 0; end
            end
            2: begin
                if (m_age == 0 && m_score > m_high) begin m_high = m_score; m_new = 1; end
                if (p || m_age == FC - 1) m_st = 3;
                else m_age++;
            end
            default: if (p) m_st = 0;
        endcase
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        trigger = 0; ball_valid = 0; reset = 1;
        @(negedge clk);
        reset = 0;
        model_reset();
    endtask

    task automatic start_game();
        drive(0, 0, 0);
        drive(1, 0, 0);
    endtask

    task automatic play_forfeit(input int pts);
        start_game();
        drive(0, 1, pts);
        drive(1, 0, 0);
        repeat (FC) drive(0, 0, 0);
        drive(1, 0, 0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        trigger = 1; reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
        model_reset();
        checks++;
        if ({state, balls_left, score, high_score, new_high} !== 19'd0) begin
            fails++; $display("FAIL reset_values: got %h expected 0", {state, balls_left, score, high_score, new_high});
        end
        checks++;
        if ({menu_state, playing_state, finish_state, score_state} !== 4'b1000) begin
            fails++; $display("FAIL reset_onehot: got %b expected 1000", {menu_state, playing_state, finish_state, score_state});
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0);
            checks++;
            if (state !== 2'b00 || menu_state !== 1'b1) begin
                fails++; $display("FAIL held_trigger: got state %b menu %b expected 00 1", state, menu_state);
            end
        end
        drive(0, 0, 0);
        drive(1, 0, 0);
        checks++;
        if (state !== 2'b01 || playing_state !== 1'b1 || balls_left !== BW'(NB)) begin
            fails++; $display("FAIL rearm_start: got state %b balls %0d expected 01 %0d", state, balls_left, NB);
        end
    endtask

    task automatic test_full_game();
        int n;
        do_reset();
        start_game();
        drive(0, 1, 10);
        checks++;
        if (score !== SW'(10) || balls_left !== BW'(2)) begin
            fails++; $display("FAIL first_ball: got score %0d balls %0d expected 10 2", score, balls_left);
        end
        drive(0, 1, 20);
        drive(0, 1, 30);
        checks++;
        if (state !== 2'b10 || score !== SW'(60) || balls_left !== BW'(0)) begin
            fails++; $display("FAIL last_ball: got state %b score %0d balls %0d expected 10 60 0", state, score, balls_left);
        end
        drive(0, 0, 0);
        checks++;
        if (high_score !== SW'(60) || new_high !== 1'b1 || state !== 2'b10) begin
            fails++; $display("FAIL high_update: got high %0d new %b state %b expected 60 1 10", high_score, new_high, state);
        end
        n = 1;
        while (state !== 2'b11 && n < 12) begin drive(0, 0, 0); n++; end
        checks++;
        if (n !== FC || score_state !== 1'b1) begin
            fails++; $display("FAIL timeout: got %0d edges in FINISH expected %0d", n, FC);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        start_game();
        drive(0, 1, 100);
        checks++;
        if (score !== SW'(100)) begin
            fails++; $display("FAIL sat_first: got %0d expected 100", score);
        end
        drive(0, 1, 100);
        checks++;
        if (score !== SW'(SMAX)) begin
            fails++; $display("FAIL sat_second: got %0d expected %0d", score, SMAX);
        end
        drive(0, 1, 100);
        checks++;
        if (score !== SW'(SMAX) || state !== 2'b10) begin
            fails++; $display("FAIL sat_third: got score %0d state %b expected %0d 10", score, state, SMAX);
        end
    endtask

    task automatic test_forfeit();
        do_reset();
        start_game();
        drive(0, 0, 0);
        drive(1, 1, 5);
        checks++;
        if (score !== SW'(5) || balls_left !== BW'(2) || state !== 2'b10) begin
            fails++; $display("FAIL forfeit_ball: got score %0d balls %0d state %b expected 5 2 10", score, balls_left, state);
        end
    endtask

    task automatic test_high_score();
        do_reset();
        start_game();
        drive(0, 1, 50);
        drive(1, 0, 0);
        repeat (FC) drive(0, 0, 0);
        checks++;
        if (state !== 2'b11 || high_score !== SW'(50) || new_high !== 1'b1) begin
            fails++; $display("FAIL game1: got state %b high %0d new %b expected 11 50 1", state, high_score, new_high);
        end
        drive(0, 1, 9);
        checks++;
        if (score !== SW'(50) || balls_left !== BW'(2)) begin
            fails++; $display("FAIL ball_in_last: got score %0d balls %0d expected 50 2", score, balls_left);
        end
        drive(1, 0, 0);
        drive(0, 1, 9);
        checks++;
        if (state !== 2'b00 || score !== SW'(50) || new_high !== 1'b1) begin
            fails++; $display("FAIL ball_in_menu: got state %b score %0d new %b expected 00 50 1", state, score, new_high);
        end
        play_forfeit(50);
        checks++;
        if (high_score !== SW'(50) || new_high !== 1'b0) begin
            fails++; $display("FAIL equal_score: got high %0d new %b expected 50 0", high_score, new_high);
        end
        play_forfeit(51);
        checks++;
        if (high_score !== SW'(51) || new_high !== 1'b1) begin
            fails++; $display("FAIL higher_score: got high %0d new %b expected 51 1", high_score, new_high);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(0, 0, 0);
        play_forfeit(60);
        start_game();
        drive(0, 1, 40);
        checks++;
        if (score !== SW'(40) || state !== 2'b01 || high_score !== SW'(60)) begin
            fails++; $display("FAIL pre_reset: got score %0d state %b high %0d expected 40 01 60", score, state, high_score);
        end
        @(negedge clk);
        #2 reset = 1;
        #1;
        checks++;
        if ({state, balls_left, score, high_score, new_high} !== 19'd0 || menu_state !== 1'b1 || playing_state !== 1'b0) begin
            fails++; $display("FAIL async_reset: got %h menu %b expected 0 1", {state, balls_left, score, high_score, new_high}, menu_state);
        end
        @(negedge clk);
        reset = 0;
        model_reset();
    endtask

    task automatic test_random();
        bit t, bv;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            t = $urandom_range(0, 99) < 35;
            bv = $urandom_range(0, 99) < 40;
            drive(t, bv, int'($urandom_range(0, SMAX)));
            checks++;
            if ({state, balls_left, score, high_score, new_high} !== exp_vec() ||
                {menu_state, playing_state, finish_state, score_state} !== 4'(1 << (3 - m_st))) begin
                fails++; $display("FAIL random_cycle_%0d: got %h expected %h", i, {state, balls_left, score, high_score, new_high}, exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_full_game();
        test_saturation();
        test_forfeit();
        test_high_score();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
